// File: rtl/arb_rr_merge.sv
// N-channel request arbiter and merge: round-robin or fixed-priority selection
// of Z-gated Send/Ack producers into a one-entry registered Send/Ack output.
module arb_rr_merge #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned DW   = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned IW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic               CLK,
  input  logic               MRn,
  input  logic [N_CH-1:0]    Send_in,
  input  logic [N_CH*DW-1:0] Data_in,
  input  logic [N_CH-1:0]    Z,
  output logic [N_CH-1:0]    Ack_in,
  output logic               Send_out,
  output logic [DW-1:0]      Data_out,
  input  logic               Ack_out,
  output logic [N_CH-1:0]    Grant,
  output logic [IW-1:0]      Grant_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  logic [IW-1:0]     ptr;

  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   win_oh;
  logic [DW-1:0]     win_data;
  logic [IW-1:0]     ptr_nxt;
  logic              found;
  logic              capture;
  int unsigned       base;
  int unsigned       best_d;
  int unsigned       d;
  int unsigned       win_int;

  // Winner is the eligible channel with the smallest circular distance from
  // the search base; a channel acked this cycle is excluded.
  always_comb begin
    elig    = Send_in & Z & ~Ack_in;
    base    = (MODE == 0) ? 32'(ptr) : 32'd0;
    best_d  = N_CH;
    win_int = 0;
    d       = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      d = (i >= base) ? (i - base) : (i + N_CH - base);
      if (elig[i] && (d < best_d)) begin
        best_d  = d;
        win_int = i;
      end
    end
    found    = (best_d < N_CH);
    win_oh   = '0;
    win_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (found && (win_int == i)) begin
        win_oh[i] = 1'b1;
        win_data  = Data_in[i*DW +: DW];
      end
    end
    capture = found && ((state == EMPTY) || Ack_out);
    ptr_nxt = (win_int == N_CH - 1) ? '0 : IW'(win_int + 1);
  end

  // Output register, acceptance pulse and round-robin pointer.
  always_ff @(posedge CLK or negedge MRn) begin
    if (!MRn) begin
      state    <= EMPTY;
      Send_out <= 1'b0;
      Data_out <= '0;
      Grant    <= '0;
      Grant_id <= '0;
      Ack_in   <= '0;
      ptr      <= '0;
    end else begin
      Ack_in <= '0;
      if (capture) begin
        state    <= FULL;
        Send_out <= 1'b1;
        Data_out <= win_data;
        Grant    <= win_oh;
        Grant_id <= IW'(win_int);
        Ack_in   <= win_oh;
        if (MODE == 0) ptr <= ptr_nxt;
      end else if ((state == FULL) && Ack_out) begin
        state    <= EMPTY;
        Send_out <= 1'b0;
        Grant    <= '0;
        Grant_id <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr_merge.sv
// Bench for arb_rr_merge: directed vector table, hand-written corner sequences
// and random traffic against a behavioural model for both policies.
module tb_arb_rr_merge;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic          CLK = 1'b0;
  logic          MRn;
  logic [N-1:0]  Send_in;
  logic [N-1:0]  Z;
  logic [N*W-1:0] Data_in;
  logic          Ack_out;

  logic [N-1:0]  ack0, ack1, gr0, gr1;
  logic          so0, so1;
  logic [W-1:0]  d0, d1;
  logic [1:0]    id0, id1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  arb_rr_merge #(.N_CH(N), .DW(W), .MODE(0)) u0 (
    .CLK(CLK), .MRn(MRn), .Send_in(Send_in), .Data_in(Data_in), .Z(Z),
    .Ack_in(ack0), .Send_out(so0), .Data_out(d0), .Ack_out(Ack_out),
    .Grant(gr0), .Grant_id(id0)
  );

  arb_rr_merge #(.N_CH(N), .DW(W), .MODE(1)) u1 (
    .CLK(CLK), .MRn(MRn), .Send_in(Send_in), .Data_in(Data_in), .Z(Z),
    .Ack_in(ack1), .Send_out(so1), .Data_out(d1), .Ack_out(Ack_out),
    .Grant(gr1), .Grant_id(id1)
  );

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  logic         m_full [2];
  logic [W-1:0] m_data [2];
  int           m_gid  [2];
  logic [N-1:0] m_ack  [2];
  int           m_ptr  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_full[m] = 1'b0;
      m_data[m] = '0;
      m_gid[m]  = 0;
      m_ack[m]  = '0;
      m_ptr[m]  = 0;
    end
  endfunction

  // One rising edge of the merge, written from the arbitration rules.
  function automatic void model_step(input int m);
    logic [N-1:0] el;
    int win;
    int c;
    el  = Send_in & Z & ~m_ack[m];
    win = -1;
    for (int k = 0; k < int'(N); k++) begin
      c = (m == 0) ? (m_ptr[m] + k) % int'(N) : k;
      if (win < 0 && el[c]) win = c;
    end
    if ((!m_full[m] || Ack_out) && win >= 0) begin
      m_full[m] = 1'b1;
      m_data[m] = Data_in[win*W +: W];
      m_gid[m]  = win;
      m_ack[m]  = N'(1) << win;
      if (m == 0) m_ptr[m] = (win + 1) % int'(N);
    end else begin
      m_ack[m] = '0;
      if (m_full[m] && Ack_out) begin
        m_full[m] = 1'b0;
        m_gid[m]  = 0;
      end
    end
  endfunction

  task automatic check_models();
    logic [N-1:0] eg;
    for (int m = 0; m < 2; m++) begin
      eg = m_full[m] ? (N'(1) << m_gid[m]) : '0;
      if (m == 0) begin
        chk("rr.send_out", 32'(so0), 32'(m_full[0]));
        chk("rr.data_out", 32'(d0),  32'(m_data[0]));
        chk("rr.grant",    32'(gr0), 32'(eg));
        chk("rr.grant_id", 32'(id0), 32'(m_full[0] ? m_gid[0] : 0));
        chk("rr.ack_in",   32'(ack0), 32'(m_ack[0]));
      end else begin
        chk("fp.send_out", 32'(so1), 32'(m_full[1]));
        chk("fp.data_out", 32'(d1),  32'(m_data[1]));
        chk("fp.grant",    32'(gr1), 32'(eg));
        chk("fp.grant_id", 32'(id1), 32'(m_full[1] ? m_gid[1] : 0));
        chk("fp.ack_in",   32'(ack1), 32'(m_ack[1]));
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!MRn) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_models();
  endtask

  typedef struct {
    logic [N-1:0] send;
    logic [N-1:0] z;
    logic         ack_out;
    logic         so;
    logic [W-1:0] dout;
    logic [N-1:0] grant;
    logic [1:0]   gid;
    logic [N-1:0] ack;
  } vec_t;

  vec_t tbl[$];

  initial begin
    MRn     = 1'b0;
    Send_in = '0;
    Z       = 4'hF;
    Data_in = 32'h4332_2110;
    Ack_out = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("reset.send_out", 32'(so0), 32'd0);
    chk("reset.grant",    32'(gr0), 32'd0);
    chk("reset.ack_in",   32'(ack0), 32'd0);
    MRn = 1'b1;

    // Round-robin fairness, drain, Z gate, backpressure, same-cycle exclusion.
    tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 8'h10, 4'b0001, 2'd0, 4'b0001});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 8'h21, 4'b0010, 2'd1, 4'b0010});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 8'h32, 4'b0100, 2'd2, 4'b0100});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 8'h43, 4'b1000, 2'd3, 4'b1000});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b1, 8'h10, 4'b0001, 2'd0, 4'b0001});
    tbl.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 8'h10, 4'b0000, 2'd0, 4'b0000});
    tbl.push_back('{4'h4, 4'hB, 1'b0, 1'b0, 8'h10, 4'b0000, 2'd0, 4'b0000});
    tbl.push_back('{4'h4, 4'hB, 1'b0, 1'b0, 8'h10, 4'b0000, 2'd0, 4'b0000});
    tbl.push_back('{4'h4, 4'hF, 1'b0, 1'b1, 8'h32, 4'b0100, 2'd2, 4'b0100});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{4'h1, 4'hF, 1'b0, 1'b1, 8'h32, 4'b0100, 2'd2, 4'b0000});
    tbl.push_back('{4'h1, 4'hF, 1'b1, 1'b1, 8'h10, 4'b0001, 2'd0, 4'b0001});
    tbl.push_back('{4'h1, 4'hF, 1'b1, 1'b0, 8'h10, 4'b0000, 2'd0, 4'b0000});
    tbl.push_back('{4'h0, 4'hF, 1'b1, 1'b0, 8'h10, 4'b0000, 2'd0, 4'b0000});

    foreach (tbl[i]) begin
      Send_in = tbl[i].send;
      Z       = tbl[i].z;
      Ack_out = tbl[i].ack_out;
      tick();
      chk($sformatf("vec%0d.send_out", i), 32'(so0),  32'(tbl[i].so));
      chk($sformatf("vec%0d.data_out", i), 32'(d0),   32'(tbl[i].dout));
      chk($sformatf("vec%0d.grant", i),    32'(gr0),  32'(tbl[i].grant));
      chk($sformatf("vec%0d.grant_id", i), 32'(id0),  32'(tbl[i].gid));
      chk($sformatf("vec%0d.ack_in", i),   32'(ack0), 32'(tbl[i].ack));
    end

    // Asynchronous reset while full; pointer must restart at 0 after release.
    Send_in = 4'b0010;
    Ack_out = 1'b0;
    tick();
    chk("pre_rst.grant_id", 32'(id0), 32'd1);
    MRn = 1'b0;
    #1;
    model_reset();
    chk("async_rst.send_out", 32'(so0), 32'd0);
    chk("async_rst.grant",    32'(gr0), 32'd0);
    chk("async_rst.ack_in",   32'(ack0), 32'd0);
    tick();
    MRn     = 1'b1;
    Send_in = 4'b0110;
    Ack_out = 1'b1;
    tick();
    chk("post_rst.ptr_grant_id", 32'(id0), 32'd1);

    // Fixed priority: lowest index first, then channel 3 after channel 1 drops.
    Send_in = 4'b0000;
    tick();
    Data_in = 32'hC300_A100;
    Send_in = 4'b1010;
    Ack_out = 1'b0;
    tick();
    chk("fp.first_data",  32'(d1),  32'hA1);
    chk("fp.first_grant", 32'(gr1), 32'b0010);
    Send_in = 4'b1000;
    Ack_out = 1'b1;
    tick();
    chk("fp.second_data", 32'(d1),  32'hC3);
    chk("fp.second_id",   32'(id1), 32'd3);

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      Send_in = N'($urandom);
      Z       = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF;
      Data_in = $urandom;
      Ack_out = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) == 0) begin
        MRn = 1'b0;
        #1;
        model_reset();
        check_models();
        tick();
        MRn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
